// File: rtl/debug_ocimem_pkg.sv
// Shared definitions for the on-chip debug memory controller.
package debug_ocimem_pkg;

  // Controller sequencing states.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_JRD  = 3'd1,
    ST_JWR  = 3'd2,
    ST_CRD  = 3'd3,
    ST_CACK = 3'd4
  } state_t;

  // Kind of JTAG operation held in the pending slot.
  typedef enum logic [1:0] {
    OP_LOAD  = 2'd0,
    OP_RD    = 2'd1,
    OP_INCRD = 2'd2,
    OP_WR    = 2'd3
  } op_t;

  // Field positions inside the 38-bit jdo command word.
  localparam int JDO_W         = 38;
  localparam int JDO_ADDR_LSB  = 17;
  localparam int JDO_RD_BIT    = 34;
  localparam int JDO_WDATA_MSB = 34;
  localparam int JDO_WDATA_LSB = 3;

endpackage

// File: rtl/debug_ocimem_ram.sv
// Single-port 2**ADDR_W x 32 debug RAM, byte-writable, registered read data.
module debug_ocimem_ram
  import debug_ocimem_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [31:0] mem [DEPTH];

  // Byte-enabled write and read-before-write data register.
  always_ff @(posedge clk) begin
    if (we && be[0]) mem[addr][7:0]   <= wdata[7:0];
    if (we && be[1]) mem[addr][15:8]  <= wdata[15:8];
    if (we && be[2]) mem[addr][23:16] <= wdata[23:16];
    if (we && be[3]) mem[addr][31:24] <= wdata[31:24];
    rdata <= mem[addr];
  end

endmodule

// File: rtl/debug_ocimem_ctrl.sv
// Debug RAM controller: JTAG monitor operations take priority over the
// CPU Avalon-MM slave; one JTAG operation may be pending at a time.
module debug_ocimem_ctrl
  import debug_ocimem_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic [3:0]        avs_byteenable,
  input  logic              avs_debugaccess,
  output logic [31:0]       avs_readdata,
  output logic              avs_waitrequest
);

  state_t            state;
  state_t            state_nxt;
  logic              pend;
  op_t               pend_op;
  logic [31:0]       pend_data;
  logic [ADDR_W-1:0] mon_a;
  logic [ADDR_W-1:0] mon_a_inc;

  logic              strobe;
  op_t               strobe_op;
  logic              cpu_wr_grant;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [3:0]        ram_be;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;

  // Command bits outside the address/data fields carry nothing for this block.
  logic unused_jdo_bits;
  assign unused_jdo_bits = ^{jdo[37:35], jdo[2:0]};

  assign mon_a_inc = mon_a + {{(ADDR_W-1){1'b0}}, 1'b1};

  // Collapse the strobes into one request; ocimem_b beats ocimem_a beats no_action.
  always_comb begin
    strobe = take_action_ocimem_b | take_action_ocimem_a | take_no_action_ocimem_a;
    if (take_action_ocimem_b) begin
      strobe_op = OP_WR;
    end else if (take_action_ocimem_a) begin
      strobe_op = jdo[JDO_RD_BIT] ? OP_RD : OP_LOAD;
    end else begin
      strobe_op = OP_INCRD;
    end
  end

  // Next state and RAM port steering; JTAG pending work is served before the CPU.
  always_comb begin
    state_nxt    = state;
    ram_addr     = mon_a;
    ram_we       = 1'b0;
    ram_be       = 4'hF;
    ram_wdata    = pend_data;
    cpu_wr_grant = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pend) begin
          case (pend_op)
            OP_RD:    state_nxt = ST_JRD;
            OP_INCRD: begin
              ram_addr  = mon_a_inc;
              state_nxt = ST_JRD;
            end
            OP_WR: begin
              ram_we    = 1'b1;
              state_nxt = ST_JWR;
            end
            default:  state_nxt = ST_IDLE;
          endcase
        end else if (avs_read) begin
          ram_addr  = avs_address;
          state_nxt = ST_CRD;
        end else if (avs_write) begin
          ram_addr     = avs_address;
          ram_be       = avs_byteenable;
          ram_wdata    = avs_writedata;
          ram_we       = avs_debugaccess;
          cpu_wr_grant = 1'b1;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_JRD:  state_nxt = ST_IDLE;
      ST_JWR:  state_nxt = ST_IDLE;
      ST_CRD:  state_nxt = ST_CACK;
      ST_CACK: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if (reset) begin
      ram_we = 1'b0;
    end else begin
      ram_we = ram_we;
    end
  end

  // The CPU is released only for an in-place write or the read acknowledge cycle.
  assign avs_waitrequest = reset | ~((state == ST_CACK) | cpu_wr_grant);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // JTAG side: strobe capture into the pending slot, then completion updates.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend          <= 1'b0;
      pend_op       <= OP_LOAD;
      pend_data     <= 32'd0;
      mon_a         <= '0;
      MonDReg       <= 32'd0;
      monitor_ready <= 1'b0;
      monitor_error <= 1'b0;
    end else begin
      if (strobe) begin
        monitor_ready <= 1'b0;
        if (pend) begin
          monitor_error <= 1'b1;
        end else begin
          pend      <= 1'b1;
          pend_op   <= strobe_op;
          pend_data <= jdo[JDO_WDATA_MSB:JDO_WDATA_LSB];
          if (strobe_op == OP_LOAD || strobe_op == OP_RD) begin
            mon_a         <= jdo[JDO_ADDR_LSB +: ADDR_W];
            monitor_error <= 1'b0;
          end
        end
      end
      // Completion is written last so it wins over a dropped strobe's ready clear.
      case (state)
        ST_IDLE: begin
          if (pend && pend_op == OP_LOAD) begin
            monitor_ready <= 1'b1;
            pend          <= 1'b0;
          end else if (pend && pend_op == OP_INCRD) begin
            mon_a <= mon_a_inc;
          end
        end
        ST_JRD: begin
          MonDReg       <= ram_rdata;
          monitor_ready <= 1'b1;
          pend          <= 1'b0;
        end
        ST_JWR: begin
          MonDReg       <= pend_data;
          mon_a         <= mon_a_inc;
          monitor_ready <= 1'b1;
          pend          <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // CPU read data register, loaded as the read leaves the RAM.
  always_ff @(posedge clk) begin
    if (reset) begin
      avs_readdata <= 32'd0;
    end else if (state == ST_CRD) begin
      avs_readdata <= ram_rdata;
    end
  end

  debug_ocimem_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .addr  (ram_addr),
    .we    (ram_we),
    .be    (ram_be),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_debug_ocimem_ctrl.sv
// Randomized bench for debug_ocimem_ctrl with a transaction-level reference model.
module tb_debug_ocimem_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [37:0] jdo = '0;
  logic        take_action_ocimem_a = 1'b0;
  logic        take_no_action_ocimem_a = 1'b0;
  logic        take_action_ocimem_b = 1'b0;
  logic [31:0] MonDReg;
  logic        monitor_ready;
  logic        monitor_error;
  logic [7:0]  avs_address = '0;
  logic        avs_read = 1'b0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic [3:0]  avs_byteenable = '0;
  logic        avs_debugaccess = 1'b0;
  logic [31:0] avs_readdata;
  logic        avs_waitrequest;

  always #5 clk = ~clk;

  debug_ocimem_ctrl #(.ADDR_W(8)) dut (
    .clk(clk), .reset(reset), .jdo(jdo),
    .take_action_ocimem_a(take_action_ocimem_a),
    .take_no_action_ocimem_a(take_no_action_ocimem_a),
    .take_action_ocimem_b(take_action_ocimem_b),
    .MonDReg(MonDReg), .monitor_ready(monitor_ready), .monitor_error(monitor_error),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
    .avs_debugaccess(avs_debugaccess), .avs_readdata(avs_readdata),
    .avs_waitrequest(avs_waitrequest)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: memory image, monitor registers, one pending JTAG op,
  // and events scheduled for the next clock edge.
  logic [31:0] mm [256];
  logic [31:0] m_mond, m_rdata, p_data, j_val, c_val;
  logic [7:0]  m_mona;
  bit          m_rdy, m_err, p_valid, j_due, j_wr, c_due, c_ack, model_live;
  int          p_op;   // 0 load, 1 read, 2 increment-read, 3 write

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // CPU is released only when the engine is free with nothing pending and a write
  // is offered, or in the cycle after a read result has been captured.
  function automatic bit exp_wait();
    if (reset) return 1'b1;
    if (c_ack) return 1'b0;
    if (!j_due && !c_due && !p_valid && !avs_read && avs_write) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void model_step();
    bit pv, rdy_set;
    int op;
    if (reset) begin
      m_mond = '0; m_rdata = '0; m_mona = '0; m_rdy = 0; m_err = 0;
      p_valid = 0; j_due = 0; c_due = 0; c_ack = 0; p_op = 0; p_data = '0;
      model_live = 1;
      return;
    end
    pv = p_valid;
    rdy_set = 0;
    if (j_due) begin
      m_mond = j_val;
      if (j_wr) m_mona = m_mona + 8'd1;
      p_valid = 0; rdy_set = 1; j_due = 0;
    end else if (c_due) begin
      m_rdata = c_val; c_due = 0; c_ack = 1;
    end else if (c_ack) begin
      c_ack = 0;
    end else if (pv) begin
      case (p_op)
        0: begin p_valid = 0; rdy_set = 1; end
        1: begin j_val = mm[m_mona]; j_wr = 0; j_due = 1; end
        2: begin m_mona = m_mona + 8'd1; j_val = mm[m_mona]; j_wr = 0; j_due = 1; end
        default: begin mm[m_mona] = p_data; j_val = p_data; j_wr = 1; j_due = 1; end
      endcase
    end else if (avs_read) begin
      c_val = mm[avs_address]; c_due = 1;
    end else if (avs_write && avs_debugaccess) begin
      for (int b = 0; b < 4; b++)
        if (avs_byteenable[b]) mm[avs_address][8*b +: 8] = avs_writedata[8*b +: 8];
    end
    if (take_action_ocimem_a || take_action_ocimem_b || take_no_action_ocimem_a) begin
      if (take_action_ocimem_b) op = 3;
      else if (take_action_ocimem_a) op = jdo[34] ? 1 : 0;
      else op = 2;
      if (pv) begin
        m_err = 1;
      end else begin
        p_valid = 1; p_op = op; p_data = jdo[34:3];
        if (op == 0 || op == 1) begin m_mona = jdo[24:17]; m_err = 0; end
      end
      m_rdy = 0;
    end
    if (rdy_set) m_rdy = 1;
  endfunction

  task automatic compare_all();
    if (!model_live) return;
    chk("MonDReg", MonDReg, m_mond);
    chk("monitor_ready", 32'(monitor_ready), 32'(m_rdy));
    chk("monitor_error", 32'(monitor_error), 32'(m_err));
    chk("avs_readdata", avs_readdata, m_rdata);
    chk("avs_waitrequest", 32'(avs_waitrequest), 32'(exp_wait()));
  endtask

  // One clock: compare on the falling edge, advance the model on the rising edge.
  task automatic step();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  function automatic logic [37:0] ja(input logic [7:0] addr, input logic rd);
    return {3'b000, rd, 9'd0, addr, 17'd0};
  endfunction

  function automatic logic [37:0] jb(input logic [31:0] data);
    return {3'b000, data, 3'b000};
  endfunction

  // kind: 0 = ocimem_a, 1 = ocimem_b, 2 = no_action_ocimem_a
  task automatic jtag(input int kind, input logic [37:0] d);
    jdo = d;
    take_action_ocimem_a    = (kind == 0);
    take_action_ocimem_b    = (kind == 1);
    take_no_action_ocimem_a = (kind == 2);
    step();
    take_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0; take_no_action_ocimem_a = 1'b0;
  endtask

  task automatic cpu_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be,
                           input logic da);
    avs_address = a; avs_writedata = d; avs_byteenable = be; avs_debugaccess = da;
    avs_write = 1'b1;
    step();
    avs_write = 1'b0;
  endtask

  task automatic cpu_read(input logic [7:0] a, output logic [31:0] d, output bit ok,
                          output bit rdy_at_ack);
    avs_address = a; avs_read = 1'b1; ok = 0; d = '0; rdy_at_ack = 0;
    for (int k = 0; k < 12; k++) begin
      #1;
      if (!avs_waitrequest) begin
        d = avs_readdata; rdy_at_ack = monitor_ready; ok = 1;
        step();
        break;
      end
      step();
    end
    avs_read = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    bit ok, rdy;
    bit cpu_busy, cpu_is_rd, w;
    logic [7:0] c_addr;
    logic [31:0] c_data;
    logic [3:0] c_be;
    logic c_da;

    // Reset held for three cycles.
    idle(3);
    chk("reset_MonDReg", MonDReg, 32'h0);
    chk("reset_ready", 32'(monitor_ready), 32'd0);
    chk("reset_error", 32'(monitor_error), 32'd0);
    chk("reset_wait", 32'(avs_waitrequest), 32'd1);
    reset = 1'b0;
    step();
    chk("post_reset_wait", 32'(avs_waitrequest), 32'd1);

    // Give every RAM word a known value.
    for (int i = 0; i < 256; i++) cpu_write(8'(i), $urandom, 4'hF, 1'b1);

    // Load, write, read back through the monitor.
    jtag(0, ja(8'h10, 1'b0)); idle(1);
    chk("load_ready", 32'(monitor_ready), 32'd1);
    jtag(1, jb(32'hDEADBEEF)); idle(1);
    chk("wr_ready_early", 32'(monitor_ready), 32'd0);
    idle(1);
    chk("wr_ready", 32'(monitor_ready), 32'd1);
    jtag(0, ja(8'h40, 1'b1)); idle(2);
    jtag(0, ja(8'h10, 1'b1)); idle(1);
    chk("rd_ready_early", 32'(monitor_ready), 32'd0);
    idle(1);
    chk("rd_ready_3cyc", 32'(monitor_ready), 32'd1);
    chk("rd_data", MonDReg, 32'hDEADBEEF);
    chk("mon_areg", 32'(dut.mon_a), 32'h10);

    // Writes wrapping from the top address, then increment-read.
    cpu_write(8'h02, 32'h0BADF00D, 4'hF, 1'b1);
    jtag(0, ja(8'hFF, 1'b0)); idle(2);
    jtag(1, jb(32'h1)); idle(3);
    jtag(1, jb(32'h2)); idle(3);
    jtag(2, 38'd0); idle(3);
    chk("incrd_after_wrap", MonDReg, 32'h0BADF00D);
    jtag(0, ja(8'hFF, 1'b1)); idle(3);
    chk("ram_ff", MonDReg, 32'h1);
    jtag(0, ja(8'h00, 1'b1)); idle(3);
    chk("ram_00", MonDReg, 32'h2);

    // CPU read colliding with a pending JTAG read.
    cpu_write(8'h20, 32'h12345678, 4'hF, 1'b1);
    jtag(0, ja(8'h33, 1'b1));
    cpu_read(8'h20, rd, ok, rdy);
    chk("cpu_rd_done", 32'(ok), 32'd1);
    chk("cpu_rd_data", rd, 32'h12345678);
    chk("jtag_first", 32'(rdy), 32'd1);

    // Byte-enabled CPU write, then a write without debug access.
    cpu_write(8'h30, 32'h11223344, 4'hF, 1'b1);
    cpu_write(8'h30, 32'hAABBCCDD, 4'b0011, 1'b1);
    cpu_write(8'h30, 32'hFFFFFFFF, 4'hF, 1'b0);
    jtag(0, ja(8'h30, 1'b1)); idle(3);
    chk("be_write", MonDReg, 32'h1122CCDD);
    cpu_read(8'h30, rd, ok, rdy);
    chk("be_write_cpu", rd, 32'h1122CCDD);

    // Strobe while an op is pending: error, first op intact, later ocimem_a clears.
    jtag(0, ja(8'h50, 1'b0)); idle(2);
    jtag(1, jb(32'hCAFEF00D));
    jtag(0, ja(8'h60, 1'b1));
    idle(1);
    chk("err_set", 32'(monitor_error), 32'd1);
    chk("err_op_ready", 32'(monitor_ready), 32'd1);
    chk("err_op_data", MonDReg, 32'hCAFEF00D);
    chk("err_mon_areg", 32'(dut.mon_a), 32'h51);
    jtag(0, ja(8'h50, 1'b1)); idle(3);
    chk("err_cleared", 32'(monitor_error), 32'd0);
    chk("err_ram", MonDReg, 32'hCAFEF00D);

    // Random traffic on both sides.
    cpu_busy = 0; cpu_is_rd = 0; c_addr = '0; c_data = '0; c_be = '0; c_da = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      int r;
      reset = ($urandom_range(0, 399) == 0);
      r = $urandom_range(0, 13);
      jdo = {6'($urandom), 32'($urandom)};
      take_action_ocimem_a    = (r == 0) || (r == 3);
      take_action_ocimem_b    = (r == 1) || (r == 3);
      take_no_action_ocimem_a = (r == 2) || (r == 3);
      if (!cpu_busy && $urandom_range(0, 2) == 0) begin
        cpu_busy = 1;
        cpu_is_rd = $urandom_range(0, 1) == 1;
        c_addr = 8'($urandom); c_data = $urandom; c_be = 4'($urandom);
        c_da = $urandom_range(0, 3) != 0;
      end
      avs_read = cpu_busy && cpu_is_rd;
      avs_write = cpu_busy && !cpu_is_rd;
      avs_address = c_addr; avs_writedata = c_data; avs_byteenable = c_be;
      avs_debugaccess = c_da;
      w = exp_wait();
      step();
      if (cpu_busy && !w) cpu_busy = 0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
